// File: rtl/ctrl_sw_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_sw_pkg
// Shared definitions for the control-channel switch:
//   - sw_state_t      : switch FSM states (RUN, GAP, LOAD)
//   - *_DEFAULT       : default parameter values of ctrl_chan_switch
//   - RST_*           : values every output takes while rst is high
//   - CNT_W           : width of the stability and dead-time counters
// ---------------------------------------------------------------------------
package ctrl_sw_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        GAP  = 2'd1,
        LOAD = 2'd2
    } sw_state_t;

    // Counters only ever need to reach 255 (max SEL_STABLE / DEAD_CYC).
    localparam int CNT_W = 8;

    localparam int   NCH_DEFAULT        = 4;
    localparam int   SEL_STABLE_DEFAULT = 4;
    localparam int   DEAD_CYC_DEFAULT   = 8;
    localparam logic DUMP_SAFE_DEFAULT  = 1'b1;

    localparam logic RST_INTERUPT  = 1'b0;
    localparam logic RST_RT_SW     = 1'b0;
    localparam logic RST_SOFT_DUMP = 1'b0;
    localparam logic RST_SW_ACQ1   = 1'b0;
    localparam logic RST_SW_ACQ2   = 1'b1;
    localparam logic RST_BUSY      = 1'b0;
    localparam logic RST_SEL_ERR   = 1'b0;

endpackage

// File: rtl/sel_stable_filter.sv
// ---------------------------------------------------------------------------
// sel_stable_filter
// Debounces the channel selector: sel is sampled every cycle and counted
// as stable once SEL_STABLE consecutive samples have been equal.
// Ports:
//   clk_sys     in   system clock
//   rst         in   synchronous active-high reset
//   sel         in   raw selector
//   sel_q       out  last sampled selector (the value being counted)
//   sel_stable  out  high once sel_q has been seen SEL_STABLE times in a row
// ---------------------------------------------------------------------------
module sel_stable_filter
    import ctrl_sw_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int SEL_STABLE = 4
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] sel_q,
    output logic             sel_stable
);

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(SEL_STABLE);

    logic [SEL_W-1:0] sel_q_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // cnt_reg holds the number of consecutive equal samples (0 = none yet,
    // e.g. right after reset). It saturates at SEL_STABLE.
    always_comb begin
        cnt_next = cnt_reg;
        if ((cnt_reg == '0) || (sel != sel_q_reg)) begin
            cnt_next = CNT_W'(1);
        end else if (cnt_reg != STABLE_CNT) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sel_q_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            sel_q_reg <= sel;
            cnt_reg   <= cnt_next;
        end
    end

    assign sel_q      = sel_q_reg;
    assign sel_stable = (cnt_reg == STABLE_CNT);

endmodule

// File: rtl/ctrl_chan_switch.sv
// ---------------------------------------------------------------------------
// ctrl_chan_switch
// Routes one of NCH per-channel control sets to a single set of registered
// outputs. Changing channel is break-before-make: the outputs are parked at
// safe values for DEAD_CYC cycles (GAP), then one LOAD cycle commits the new
// channel, then RUN resumes tracking.
// Ports:
//   clk_sys    in   system clock
//   rst        in   synchronous active-high reset
//   sel        in   requested channel (debounced over SEL_STABLE cycles)
//   acq_echo   in   acquisition path: 1 = echo, 0 = pulse
//   inter_in   in   per-channel interrupt, active-low
//   rt_sw_in   in   per-channel RT switch control
//   s_dump_in  in   per-channel soft dump control
//   int_clr    in   clears the sticky interrupt (latch build only)
//   interupt, rt_sw, soft_dump, sw_acq1, sw_acq2  out  qualified controls
//   active_ch  out  channel currently driving the outputs
//   busy       out  high during GAP and LOAD
//   sel_err    out  high (one cycle later) while sel >= NCH
// Build option:
//   CTRL_SW_INT_LATCH_EN  - interupt becomes a sticky flag set by a rising
//                           edge of the active channel's interrupt and
//                           cleared by int_clr, GAP entry or reset.
// ---------------------------------------------------------------------------
module ctrl_chan_switch
    import ctrl_sw_pkg::*;
#(
    parameter int   NCH        = NCH_DEFAULT,
    parameter int   SEL_W      = $clog2(NCH),
    parameter int   SEL_STABLE = SEL_STABLE_DEFAULT,
    parameter int   DEAD_CYC   = DEAD_CYC_DEFAULT,
    parameter logic DUMP_SAFE  = DUMP_SAFE_DEFAULT
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel,
    input  logic             acq_echo,
    input  logic [NCH-1:0]   inter_in,
    input  logic [NCH-1:0]   rt_sw_in,
    input  logic [NCH-1:0]   s_dump_in,
    input  logic             int_clr,
    output logic             interupt,
    output logic             rt_sw,
    output logic             soft_dump,
    output logic             sw_acq1,
    output logic             sw_acq2,
    output logic [SEL_W-1:0] active_ch,
    output logic             busy,
    output logic             sel_err
);

    localparam int               NSEL      = 2 ** SEL_W;
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);

    // Per-channel inputs padded to the full selector range so any sel value
    // can index them; valid_map marks the channels that really exist.
    logic [NSEL-1:0] valid_map;
    logic [NSEL-1:0] inter_pad;
    logic [NSEL-1:0] rt_pad;
    logic [NSEL-1:0] dump_pad;

    genvar gi;
    generate
        for (gi = 0; gi < NSEL; gi++) begin : g_pad
            if (gi < NCH) begin : g_ch
                assign valid_map[gi] = 1'b1;
                assign inter_pad[gi] = inter_in[gi];
                assign rt_pad[gi]    = rt_sw_in[gi];
                assign dump_pad[gi]  = s_dump_in[gi];
            end else begin : g_none
                assign valid_map[gi] = 1'b0;
                assign inter_pad[gi] = 1'b1;
                assign rt_pad[gi]    = 1'b0;
                assign dump_pad[gi]  = 1'b0;
            end
        end
    endgenerate

    logic [SEL_W-1:0] sel_q;
    logic             sel_stable;

    sel_stable_filter #(
        .SEL_W      (SEL_W),
        .SEL_STABLE (SEL_STABLE)
    ) u_sel_filter (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .sel        (sel),
        .sel_q      (sel_q),
        .sel_stable (sel_stable)
    );

    sw_state_t        state_reg,    state_next;
    logic [SEL_W-1:0] active_ch_reg, active_ch_next;
    logic [SEL_W-1:0] pend_ch_reg,   pend_ch_next;
    logic [CNT_W-1:0] dead_cnt_reg,  dead_cnt_next;

    logic interupt_reg,  interupt_next;
    logic rt_sw_reg,     rt_sw_next;
    logic soft_dump_reg, soft_dump_next;
    logic sw_acq1_reg,   sw_acq1_next;
    logic sw_acq2_reg,   sw_acq2_next;
    logic busy_reg,      busy_next;
    logic sel_err_reg,   sel_err_next;
    logic run_next;

    // Switch FSM
    always_comb begin
        state_next     = state_reg;
        active_ch_next = active_ch_reg;
        pend_ch_next   = pend_ch_reg;
        dead_cnt_next  = dead_cnt_reg;
        case (state_reg)
            RUN: begin
                if (sel_stable && valid_map[sel_q] && (sel_q != active_ch_reg)) begin
                    state_next    = GAP;
                    pend_ch_next  = sel_q;
                    dead_cnt_next = '0;
                end
            end
            GAP: begin
                if (dead_cnt_reg == DEAD_LAST) begin
                    state_next = LOAD;
                end else begin
                    dead_cnt_next = dead_cnt_reg + CNT_W'(1);
                end
            end
            LOAD: begin
                active_ch_next = pend_ch_reg;
                dead_cnt_next  = '0;
                state_next     = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Outputs are computed from the next state/channel so that the registered
    // value is already correct in the cycle the FSM arrives in a state.
    always_comb begin
        run_next       = (state_next == RUN);
        rt_sw_next     = run_next ? rt_pad[active_ch_next]   : 1'b0;
        soft_dump_next = run_next ? dump_pad[active_ch_next] : DUMP_SAFE;
        sw_acq1_next   = run_next &  acq_echo;
        sw_acq2_next   = run_next & ~acq_echo;
        busy_next      = ~run_next;
        sel_err_next   = ~valid_map[sel];
    end

`ifdef CTRL_SW_INT_LATCH_EN
    // Raw interrupt of the channel that will be active next; following
    // active_ch_next keeps the edge history on the new channel from LOAD on,
    // so a level already present at switch time is not seen as an edge.
    logic int_raw;
    logic int_prev_reg;
    logic int_rise;

    always_comb begin
        int_raw  = ~inter_pad[active_ch_next];
        int_rise = (state_reg == RUN) & int_raw & ~int_prev_reg;
        interupt_next = interupt_reg;
        if (!run_next) begin
            interupt_next = 1'b0;
        end else if (int_clr) begin
            interupt_next = 1'b0;
        end else if (int_rise) begin
            interupt_next = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            int_prev_reg <= 1'b0;
        end else begin
            int_prev_reg <= int_raw;
        end
    end
`else
    logic unused_int_clr;
    assign unused_int_clr = int_clr;

    always_comb begin
        interupt_next = run_next ? ~inter_pad[active_ch_next] : 1'b0;
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_reg     <= RUN;
            active_ch_reg <= '0;
            pend_ch_reg   <= '0;
            dead_cnt_reg  <= '0;
            interupt_reg  <= RST_INTERUPT;
            rt_sw_reg     <= RST_RT_SW;
            soft_dump_reg <= RST_SOFT_DUMP;
            sw_acq1_reg   <= RST_SW_ACQ1;
            sw_acq2_reg   <= RST_SW_ACQ2;
            busy_reg      <= RST_BUSY;
            sel_err_reg   <= RST_SEL_ERR;
        end else begin
            state_reg     <= state_next;
            active_ch_reg <= active_ch_next;
            pend_ch_reg   <= pend_ch_next;
            dead_cnt_reg  <= dead_cnt_next;
            interupt_reg  <= interupt_next;
            rt_sw_reg     <= rt_sw_next;
            soft_dump_reg <= soft_dump_next;
            sw_acq1_reg   <= sw_acq1_next;
            sw_acq2_reg   <= sw_acq2_next;
            busy_reg      <= busy_next;
            sel_err_reg   <= sel_err_next;
        end
    end

    assign interupt  = interupt_reg;
    assign rt_sw     = rt_sw_reg;
    assign soft_dump = soft_dump_reg;
    assign sw_acq1   = sw_acq1_reg;
    assign sw_acq2   = sw_acq2_reg;
    assign active_ch = active_ch_reg;
    assign busy      = busy_reg;
    assign sel_err   = sel_err_reg;

endmodule
